// File: rtl/hilo_acc_unit_pkg.sv
// Shared definitions for the HI/LO accumulate unit: op codes, FSM states,
// and the common 32-bit register-bus types.
package hilo_acc_unit_pkg;

    localparam int REG_BUS_W = 32;
    typedef logic [REG_BUS_W-1:0] reg_bus_t;
    localparam reg_bus_t ZERO_WORD = '0;

    typedef enum logic [2:0] {
        HILO_NOP   = 3'd0,
        HILO_WHI   = 3'd1,
        HILO_WLO   = 3'd2,
        HILO_WBOTH = 3'd3,
        HILO_MADD  = 3'd4,
        HILO_MSUB  = 3'd5
    } hilo_op_e;

    typedef enum logic [1:0] {
        HILO_IDLE   = 2'd0,
        HILO_ACC_LO = 2'd1,
        HILO_ACC_HI = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_addsub.sv
// Combinational DATA_W add/subtract with carry-in and carry-out.
// In subtract mode ci is a borrow-in and co is the borrow-out.
module hilo_addsub #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ci,
    input  logic              sub,
    output logic [DATA_W-1:0] s,
    output logic              co
);

    logic [DATA_W:0] a_ext;
    logic [DATA_W:0] b_ext;
    logic [DATA_W:0] c_ext;
    logic [DATA_W:0] res_ext;

    always_comb begin
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        c_ext = {{DATA_W{1'b0}}, ci};
        // With a zero-extended minuend, the top bit of a negative result is the borrow.
        if (sub) res_ext = a_ext - b_ext - c_ext;
        else     res_ext = a_ext + b_ext + c_ext;
        s  = res_ext[DATA_W-1:0];
        co = res_ext[DATA_W];
    end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO special-register unit: direct writes plus a two-cycle MADD/MSUB
// accumulate that commits HI and LO on the same edge.
module hilo_acc_unit
    import hilo_acc_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_code,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic                flush,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                done_o
);

    hilo_state_e       state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0] lo_sum_q, lo_sum_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;

    logic              op_is_msub;
    logic [DATA_W-1:0] lo_sum;
    logic              lo_co;
    logic [DATA_W-1:0] hi_new;
    logic              hi_co_unused;

    assign op_is_msub = (op_code == OP_W'(HILO_MSUB));

    hilo_addsub #(.DATA_W(DATA_W)) u_lo_addsub (
        .a   (lo_q),
        .b   (acc_i[DATA_W-1:0]),
        .ci  (1'b0),
        .sub (op_is_msub),
        .s   (lo_sum),
        .co  (lo_co)
    );

    // High half uses only latched operands so the commit cycle is independent of inputs.
    hilo_addsub #(.DATA_W(DATA_W)) u_hi_addsub (
        .a   (hi_q),
        .b   (acc_hi_q),
        .ci  (carry_q),
        .sub (sub_q),
        .s   (hi_new),
        .co  (hi_co_unused)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        acc_hi_d = acc_hi_q;
        lo_sum_d = lo_sum_q;
        carry_d  = carry_q;
        sub_d    = sub_q;

        case (state_q)
            HILO_IDLE: begin
                if (op_valid && !flush) begin
                    case (op_code)
                        OP_W'(HILO_WHI):   hi_d = hi_i;
                        OP_W'(HILO_WLO):   lo_d = lo_i;
                        OP_W'(HILO_WBOTH): begin
                            hi_d = hi_i;
                            lo_d = lo_i;
                        end
                        OP_W'(HILO_MADD), OP_W'(HILO_MSUB): begin
                            acc_hi_d = acc_i[2*DATA_W-1:DATA_W];
                            sub_d    = op_is_msub;
                            lo_sum_d = lo_sum;
                            carry_d  = lo_co;
                            state_d  = HILO_ACC_LO;
                        end
                        default: ;
                    endcase
                end
            end
            HILO_ACC_LO: begin
                if (flush) begin
                    state_d = HILO_IDLE;
                end else begin
                    hi_d    = hi_new;
                    lo_d    = lo_sum_q;
                    done_d  = 1'b1;
                    state_d = HILO_ACC_HI;
                end
            end
            HILO_ACC_HI: state_d = HILO_IDLE;
            default:     state_d = HILO_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HILO_IDLE;
            hi_q     <= DATA_W'(ZERO_WORD);
            lo_q     <= DATA_W'(ZERO_WORD);
            done_q   <= 1'b0;
            acc_hi_q <= '0;
            lo_sum_q <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            acc_hi_q <= acc_hi_d;
            lo_sum_q <= lo_sum_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
        end
    end

    assign op_ready = (state_q == HILO_IDLE);
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed-vector bench for hilo_acc_unit with hand-computed expectations.
module tb_hilo_acc_unit;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WHI   = 3'd1;
    localparam logic [2:0] OP_WLO   = 3'd2;
    localparam logic [2:0] OP_WBOTH = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                op_valid = 1'b0;
    logic                op_ready;
    logic [OP_W-1:0]     op_code = '0;
    logic [DATA_W-1:0]   hi_i = '0;
    logic [DATA_W-1:0]   lo_i = '0;
    logic [2*DATA_W-1:0] acc_i = '0;
    logic                flush = 1'b0;
    logic [DATA_W-1:0]   hi_o;
    logic [DATA_W-1:0]   lo_o;
    logic                done_o;

    int n_vec = 0;
    int n_mis = 0;

    hilo_acc_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .acc_i    (acc_i),
        .flush    (flush),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wboth(input logic [31:0] h, input logic [31:0] l);
        op_valid = 1'b1; op_code = OP_WBOTH; hi_i = h; lo_i = l;
        step();
        op_valid = 1'b0;
    endtask

    // Preload HI/LO, run one accumulate, check commit timing and result.
    task automatic do_acc(input string tag, input logic [2:0] op, input logic [31:0] h0,
                          input logic [31:0] l0, input logic [63:0] acc,
                          input logic [31:0] eh, input logic [31:0] el);
        wboth(h0, l0);
        op_valid = 1'b1; op_code = op; acc_i = acc;
        step();
        op_valid = 1'b0; acc_i = '0;
        chk({tag, "_busy_lo"}, lo_o, l0);
        step();
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
        chk({tag, "_done"}, done_o, 1'b1);
        step();
        chk({tag, "_done_clr"}, done_o, 1'b0);
        chk({tag, "_ready"}, op_ready, 1'b1);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_done", done_o, 1'b0);

        wboth(32'h12345678, 32'h9ABCDEF0);
        chk("wboth_hi", hi_o, 32'h12345678);
        chk("wboth_lo", lo_o, 32'h9ABCDEF0);
        chk("wboth_ready", op_ready, 1'b1);

        op_valid = 1'b1; op_code = OP_WLO; lo_i = 32'h1; hi_i = 32'hDEADBEEF;
        step();
        op_valid = 1'b0;
        chk("wlo_lo", lo_o, 32'h1);
        chk("wlo_hi", hi_o, 32'h12345678);

        // MADD carry with a WHI held while busy.
        wboth(32'h0, 32'hFFFFFFFF);
        op_valid = 1'b1; op_code = OP_MADD; acc_i = 64'h1;
        step();
        chk("madd_ready0", op_ready, 1'b0);
        chk("madd_done0", done_o, 1'b0);
        chk("madd_hold_hi", hi_o, 32'h0);
        chk("madd_hold_lo", lo_o, 32'hFFFFFFFF);
        op_code = OP_WHI; hi_i = 32'hA5A5A5A5; acc_i = '0;
        step();
        chk("madd_hi", hi_o, 32'h1);
        chk("madd_lo", lo_o, 32'h0);
        chk("madd_done", done_o, 1'b1);
        chk("madd_ready1", op_ready, 1'b0);
        step();
        chk("whi_not_yet", hi_o, 32'h1);
        chk("madd_done_clr", done_o, 1'b0);
        chk("madd_ready2", op_ready, 1'b1);
        step();
        op_valid = 1'b0;
        chk("whi_late_hi", hi_o, 32'hA5A5A5A5);
        chk("whi_late_lo", lo_o, 32'h0);

        do_acc("msub_wrap", OP_MSUB, 32'h0, 32'h0, 64'h1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_acc("madd_mix", OP_MADD, 32'h10, 32'h80000000, 64'h00000002_80000001,
               32'h00000013, 32'h00000001);
        do_acc("msub_nb", OP_MSUB, 32'h5, 32'hA, 64'h00000001_00000003,
               32'h00000004, 32'h00000007);
        do_acc("madd_wrap", OP_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001,
               32'h00000000, 32'h00000000);

        // Flush in ACC_LO cancels the accumulate.
        wboth(32'h11, 32'h22);
        op_valid = 1'b1; op_code = OP_MADD; acc_i = 64'h5;
        step();
        op_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_lo_hi", hi_o, 32'h11);
        chk("fl_lo_lo", lo_o, 32'h22);
        chk("fl_lo_done", done_o, 1'b0);
        chk("fl_lo_ready", op_ready, 1'b1);
        step();
        chk("fl_lo_done2", done_o, 1'b0);
        chk("fl_lo_lo2", lo_o, 32'h22);

        // Flush in ACC_HI: commit already happened.
        op_valid = 1'b1; op_code = OP_MADD; acc_i = 64'h5;
        step();
        op_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_hi_lo", lo_o, 32'h27);
        chk("fl_hi_hi", hi_o, 32'h11);
        chk("fl_hi_ready", op_ready, 1'b1);

        // Flush with accept in IDLE drops the op.
        op_valid = 1'b1; op_code = OP_WHI; hi_i = 32'hBEEF; flush = 1'b1;
        step();
        chk("fl_idle_hi", hi_o, 32'h11);
        op_code = OP_MADD; acc_i = 64'h1_00000001;
        step();
        chk("fl_idle_madd_ready", op_ready, 1'b1);
        flush = 1'b0;
        op_code = 3'd7; hi_i = 32'hCAFE0001; lo_i = 32'hCAFE0002;
        step();
        chk("rsvd_hi", hi_o, 32'h11);
        chk("rsvd_lo", lo_o, 32'h27);
        chk("rsvd_ready", op_ready, 1'b1);
        op_code = OP_NOP;
        step();
        chk("nop_hi", hi_o, 32'h11);
        chk("nop_lo", lo_o, 32'h27);
        op_valid = 1'b0;

        // Async reset mid-accumulate abandons it.
        op_valid = 1'b1; op_code = OP_MADD; acc_i = 64'h5;
        step();
        op_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_hi", hi_o, 32'h0);
        chk("arst_lo", lo_o, 32'h0);
        chk("arst_ready", op_ready, 1'b1);
        chk("arst_done", done_o, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("arst_done2", done_o, 1'b0);
        chk("arst_lo2", lo_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
- Parametrised HI/LO special-register unit for the MEM/WB boundary.
- Holds the HI and LO architectural registers, each DATA_W bits wide.
- Supports direct writes plus multi-cycle multiply-accumulate/subtract (MADD/MSUB) of a 2*DATA_W product into the {HI,LO} pair.
- The accumulate is split across two cycles: low half, then high half with carry. Commit is atomic, and a pending accumulate can be flushed on exception.

Parameters:
- DATA_W, 32, width of HI and of LO; the accumulator is 2*DATA_W.
- OP_W, 3, width of the op code field.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  an op is presented this cycle
- op_ready  out  1  unit can accept an op; equals (state==IDLE)
- op_code  in  OP_W  0 NOP, 1 WHI, 2 WLO, 3 WBOTH, 4 MADD, 5 MSUB; 6-7 reserved, treated as NOP
- hi_i  in  DATA_W  write data for HI (WHI/WBOTH)
- lo_i  in  DATA_W  write data for LO (WLO/WBOTH)
- acc_i  in  2*DATA_W  product operand for MADD/MSUB
- flush  in  1  cancel any in-flight accumulate
- hi_o  out  DATA_W  architectural HI
- lo_o  out  DATA_W  architectural LO
- done_o  out  1  one-cycle pulse when an accumulate commits

Behaviour:
- Reset (async, rst=1):
  - hi_o=0, lo_o=0, done_o=0, state=IDLE, op_ready=1.
  - Internal temporaries (acc_hi_q, lo_sum_q, carry_q, sub_q) are cleared.
  - Reset asserted mid-accumulate abandons the accumulate with no commit.
- Accept condition: op_valid && op_ready. An op_valid while op_ready=0 is ignored; the issuer must hold it.
- Writes (WHI/WLO/WBOTH):
  - Single cycle: the selected register(s) update on the accepting edge.
  - The unselected register holds.
  - op_ready stays 1.
- NOP and reserved codes: no state change.
- Accumulate state machine: IDLE -> ACC_LO -> ACC_HI -> IDLE.
  - IDLE, accept MADD/MSUB:
    - Latch acc_i[2W-1:W] into acc_hi_q and sub_q = (op==MSUB).
    - Compute lo_sum = lo_o + acc_i[W-1:0] for MADD, or lo_o - acc_i[W-1:0] for MSUB.
    - Latch lo_sum into lo_sum_q, and carry (MADD) or borrow (MSUB) into carry_q.
    - Next state ACC_LO.
  - ACC_LO:
    - Compute hi_new = hi_o + acc_hi_q + carry_q for MADD, or hi_o - acc_hi_q - carry_q for MSUB.
    - Next edge: hi_o<=hi_new, lo_o<=lo_sum_q in the same edge (atomic), done_o=1 for that cycle, state to ACC_HI.
  - ACC_HI:
    - One-cycle drain; done_o returns to 0 and state goes to IDLE.
    - Guarantees one bubble so the next reader sees committed values.
- Latency:
  - Accept to commit is 2 edges.
  - op_ready is low for 2 cycles after accept; the next op can be accepted in the 3rd cycle.
- Arithmetic:
  - Unsigned modulo 2^(2*DATA_W); wrap-around is silent.
  - The signed/unsigned distinction is the producer's job: the product arrives already sign-extended in 2W bits.
- Flush:
  - Flush in ACC_LO: state goes to IDLE, no commit, done_o=0.
  - Flush in ACC_HI: the commit has already happened, so no effect beyond returning to IDLE.
  - Flush in IDLE: if the same cycle also accepts an op, the op is dropped (flush has priority).
- Outputs: hi_o/lo_o are purely registered and change only on commit or write edges.

Decomposition:
- Shared defines file, alongside the existing global defines:
  - Op code constants: HILO_NOP, HILO_WHI, HILO_WLO, HILO_WBOTH, HILO_MADD, HILO_MSUB.
  - State encodings HILO_IDLE/ACC_LO/ACC_HI.
  - Reuse ZeroWord and RegBus where DATA_W=32.
- One natural sub-module, hilo_addsub: combinational DATA_W add/sub with carry-in/carry-out. It is instantiated twice, once for the low half and once for the high half.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> hi_o=0, lo_o=0, op_ready=1, done_o=0 immediately.
- WBOTH hi_i=0x12345678, lo_i=0x9ABCDEF0 -> both visible after 1 edge. Follow with WLO lo_i=1 -> lo_o=1, hi_o unchanged.
- MADD carry: HI=0, LO=0xFFFFFFFF, acc_i=0x0000_0000_0000_0001.
  - After 2 edges: hi_o=1, lo_o=0, done_o pulse.
  - op_ready is low for 2 cycles.
  - A WHI held during busy is accepted only in the 3rd cycle.
- MSUB borrow and wrap: HI=0, LO=0, acc_i=1 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF.
- Flush in ACC_LO after MADD acc_i=5 -> hi_o/lo_o unchanged, no done_o, op_ready=1 next cycle.
- Flush and accept together: flush=1 with op_valid WHI in IDLE -> no write. Reserved op_code 7 -> no state change.
